// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues one aligned data-bus request per load/store and holds the result for writeback.
// Optional feature: define MEM_MMIO_SKIP_EN to flag accesses below 0x8000_0000 as difftest skips.
module memory_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic [63:0] in_value,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    input  logic [1:0]  in_kind,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    input  logic        flush,
    output logic        dreq_valid,
    output logic        dreq_write,
    output logic [63:0] dreq_addr,
    output logic [7:0]  dreq_strobe,
    output logic [63:0] dreq_wdata,
    input  logic        dresp_valid,
    input  logic [63:0] dresp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst,
    output logic [63:0] out_value,
    output logic        out_trap_valid,
    output logic [3:0]  out_trap_code,
    output logic        out_skip
);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_t;
    localparam logic [1:0] K_LOAD = 2'd1, K_STORE = 2'd2;

    state_t      state, state_nx;
    logic [63:0] pc_q, value_q, addr_q, wdata_q;
    logic [31:0] inst_q;
    logic [1:0]  kind_q, size_q;
    logic        uns_q, trap_q;
    logic [3:0]  trap_code_q;
    logic        accept, is_mem_in, misalign_in;
    logic [63:0] shifted, load_val;
    logic [7:0]  mask;

    assign accept    = (state == IDLE) && in_valid && !flush;
    assign is_mem_in = (in_kind == K_LOAD) || (in_kind == K_STORE);

    always_comb begin
        misalign_in = 1'b0;
        case (in_size)
            2'd0: misalign_in = 1'b0;
            2'd1: misalign_in = in_addr[0];
            2'd2: misalign_in = |in_addr[1:0];
            2'd3: misalign_in = |in_addr[2:0];
        endcase
    end

    // A flush coinciding with the response still ends the transaction, so it goes straight to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = (is_mem_in && !misalign_in) ? REQ : HOLD;
            REQ:   if (dresp_valid) state_nx = flush ? IDLE : HOLD;
                   else if (flush) state_nx = DRAIN;
            DRAIN: if (dresp_valid) state_nx = IDLE;
            HOLD:  if (flush || out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign shifted = dresp_data >> {addr_q[2:0], 3'b000};
    always_comb begin
        load_val = 64'd0;
        case (size_q)
            2'd0: load_val = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
            2'd1: load_val = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
            2'd2: load_val = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
            2'd3: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc_q        <= '0;
            inst_q      <= '0;
            value_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            kind_q      <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            trap_q      <= 1'b0;
            trap_code_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                pc_q        <= in_pc;
                inst_q      <= in_inst;
                value_q     <= in_value;
                addr_q      <= in_addr;
                wdata_q     <= in_wdata;
                kind_q      <= in_kind;
                size_q      <= in_size;
                uns_q       <= in_unsigned;
                trap_q      <= is_mem_in && misalign_in;
                trap_code_q <= (in_kind == K_LOAD) ? 4'd4 : 4'd6;
            end else if (state == REQ && dresp_valid && !flush && kind_q == K_LOAD) begin
                value_q <= load_val;
            end
        end
    end

`ifdef MEM_MMIO_SKIP_EN
    logic skip_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         skip_q <= 1'b0;
        else if (accept) skip_q <= is_mem_in && !in_addr[31];
    end
    assign out_skip = (state == HOLD) && skip_q;
`else
    assign out_skip = 1'b0;
`endif

    always_comb begin
        mask = 8'h00;
        case (size_q)
            2'd0: mask = 8'h01;
            2'd1: mask = 8'h03;
            2'd2: mask = 8'h0F;
            2'd3: mask = 8'hFF;
        endcase
    end

    // Request fields derive only from latched state, so they stay stable through REQ and DRAIN.
    assign in_ready       = (state == IDLE);
    assign dreq_valid     = (state == REQ) || (state == DRAIN);
    assign dreq_write     = (kind_q == K_STORE);
    assign dreq_addr      = {addr_q[63:3], 3'b000};
    assign dreq_strobe    = (kind_q == K_STORE) ? (mask << addr_q[2:0]) : 8'h00;
    assign dreq_wdata     = wdata_q << {addr_q[2:0], 3'b000};
    assign out_valid      = (state == HOLD);
    assign out_pc         = pc_q;
    assign out_inst       = inst_q;
    assign out_value      = value_q;
    assign out_trap_valid = (state == HOLD) && trap_q;
    assign out_trap_code  = trap_code_q;
endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have ports: clk in 1, single pipeline clock; rst in 1, asynchronous active-high reset.
REQ-002 SHALL have: in_valid in 1, execute result valid; in_ready out 1, stage can accept.
REQ-003 SHALL have: in_pc in 64; in_inst in 32; in_value in 64 (ALU result); in_addr in 64; in_wdata in 64.
REQ-004 SHALL have: in_kind in 2 (0 none, 1 load, 2 store); in_size in 2 (0 B, 1 H, 2 W, 3 D); in_unsigned in 1.
REQ-005 SHALL have: flush in 1, discard held/in-flight instruction.
REQ-006 SHALL have: dreq_valid out 1; dreq_write out 1; dreq_addr out 64; dreq_strobe out 8; dreq_wdata out 64.
REQ-007 SHALL have: dresp_valid in 1, one-cycle data_ok pulse; dresp_data in 64.
REQ-008 SHALL have: out_valid out 1; out_ready in 1 (writeback latch accepts); out_pc out 64; out_inst out 32; out_value out 64.
REQ-009 SHALL have: out_trap_valid out 1; out_trap_code out 4; out_skip out 1 (difftest skip).

Function
REQ-010 SHALL implement states IDLE, REQ, DRAIN, HOLD.
REQ-011 IDLE: in_ready=1; accept on in_valid && !flush, latching all in_* fields.
REQ-012 Accepted kind=none: go HOLD next cycle, out_value=in_value, no bus request (1-cycle latency).
REQ-013 Misaligned access (in_addr mod 2^size != 0): go HOLD, no bus request, out_trap_valid=1, out_trap_code=4 (load) or 6 (store).
REQ-014 Aligned load/store: go REQ; dreq_valid=1 with dreq_addr={in_addr[63:3],3'b0}, dreq_write=(kind==store).
REQ-015 Store: dreq_strobe = (1,3,15,255 per size) << addr[2:0]; dreq_wdata = in_wdata << (8*addr[2:0]); load strobe=0.
REQ-016 REQ: dreq_* held stable until dresp_valid; on dresp_valid go HOLD, dreq_valid=0 same edge.
REQ-017 Load result: dresp_data >> (8*addr[2:0]), truncated to size, zero-extended if in_unsigned else sign-extended to 64; store out_value=in_value.
REQ-018 HOLD: out_valid=1, in_ready=0; on out_ready go IDLE; in_ready only asserts in IDLE (no same-cycle re-accept).
REQ-019 flush in IDLE or HOLD: go IDLE, out_valid=0 next cycle.
REQ-020 flush in REQ: bus transaction not abortable; go DRAIN, keep dreq_* stable, discard response, go IDLE on dresp_valid.
REQ-021 flush and dresp_valid same cycle in REQ: go IDLE directly, result discarded.
REQ-022 out_valid SHALL never assert in REQ or DRAIN; out_* held stable throughout HOLD.

Reset
REQ-023 rst SHALL immediately force IDLE; in_ready=1, dreq_valid=0, out_valid=0, out_trap_valid=0, out_skip=0, dreq_strobe=0, all data outputs 0.
REQ-024 Reset during REQ SHALL abandon the request; a dresp_valid arriving after reset release in IDLE SHALL be ignored.

Configuration
REQ-025 Macro MEM_MMIO_SKIP_EN defined: out_skip=1 in HOLD for load/store with latched in_addr[31]==0 (MMIO region).
REQ-026 Without MEM_MMIO_SKIP_EN: out_skip tied 0; all other behaviour identical.

Verification
REQ-027 Load B signed, addr 0x80000003, dresp_data 0x00000000_80FF0000 -> dreq_addr 0x80000000, out_value 0xFFFFFFFF_FFFFFF80 one cycle after dresp_valid.
REQ-028 Store H, addr 0x80000006, wdata 0x1234 -> dreq_strobe 0xC0, dreq_wdata 0x1234_0000_0000_0000, dreq_write=1, out_value=in_value.
REQ-029 Load W at addr 0x80000002 -> no dreq_valid, HOLD next cycle, out_trap_valid=1, out_trap_code=4.
REQ-030 flush 2 cycles into REQ, dresp_valid 3 cycles later -> dreq stable until response, out_valid never asserts, in_ready=1 next cycle.
REQ-031 HOLD with out_ready=0 for 5 cycles -> out_* stable, in_ready=0; out_ready=1 -> IDLE next cycle; MMIO load addr 0x10000000 with MEM_MMIO_SKIP_EN -> out_skip=1, without -> 0.
